// File: rtl/cpu_check_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_check_pkg
// Description : Shared types and constants for the core-side checker tap.
//               retire_rec_t is one retired-instruction record as seen by the
//               checker: the retiring pc and the value it wrote (0 if none).
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_check_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         NUM_REGS = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd_value;
    } retire_rec_t;

    // Build a retire record; writes to register 0 are architecturally void,
    // so they report a zero result just like an instruction with no write.
    function automatic retire_rec_t make_retire_rec(
        input logic [31:0] pc,
        input logic        wr_en,
        input logic [4:0]  wr_addr,
        input logic [31:0] wr_data
    );
        retire_rec_t rec;
        rec.pc       = pc;
        rec.rd_value = (wr_en && (wr_addr != REG_ZERO)) ? wr_data : 32'd0;
        return rec;
    endfunction

endpackage : cpu_check_pkg
`default_nettype wire

// File: rtl/cpu_state_tap_retire_fifo.sv
`default_nettype none
// ============================================================================
// Module      : retire_fifo
// Description : Small power-of-two FIFO of retire records. Drops a push when
//               full unless a pop happens in the same cycle. When empty, the
//               head output holds the last popped record (0 after reset).
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_push          - write i_push_data this cycle
//               i_push_data     - record to enqueue
//               i_pop           - consume head (ignored while empty)
//               o_head          - head record / last popped record if empty
//               o_empty         - FIFO holds no entries
//               o_drop          - push discarded this cycle (full, no pop)
// Revision    : 1.0 - initial release
// ============================================================================
module retire_fifo
    import cpu_check_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  retire_rec_t i_push_data,
    input  logic        i_pop,
    output retire_rec_t o_head,
    output logic        o_empty,
    output logic        o_drop
);

    localparam int c_ADDR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate counter.
    logic [c_ADDR_W:0]   r_wr_ptr;
    logic [c_ADDR_W:0]   r_rd_ptr;
    retire_rec_t         r_mem [DEPTH];
    retire_rec_t         r_last;

    logic                w_full;
    logic                w_empty;
    logic                w_pop_ok;
    logic                w_push_ok;
    logic [c_ADDR_W-1:0] w_wr_idx;
    logic [c_ADDR_W-1:0] w_rd_idx;

    assign w_wr_idx  = r_wr_ptr[c_ADDR_W-1:0];
    assign w_rd_idx  = r_rd_ptr[c_ADDR_W-1:0];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_ADDR_W] != r_rd_ptr[c_ADDR_W]) &&
                       (w_wr_idx == w_rd_idx);
    assign w_pop_ok  = i_pop && !w_empty;
    // A simultaneous pop frees the slot, so a push at full is still accepted.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_last   <= r_mem[w_rd_idx];
            end
        end
    end

    // Storage needs no reset: a slot is only read after it has been written.
    // At full with a pop, the write lands in the slot being popped; the old
    // contents are consumed (and captured in r_last) at this same edge.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    assign o_head  = w_empty ? r_last : r_mem[w_rd_idx];
    assign o_empty = w_empty;
    assign o_drop  = i_push && w_full && !w_pop_ok;

endmodule : retire_fifo
`default_nettype wire

// File: rtl/cpu_state_tap.sv
`default_nettype none
// ============================================================================
// Module      : cpu_state_tap
// Description : Core-side checker responder. Snoops core writeback/retire,
//               keeps a shadow 32x32 register file, answers rs/rt queries
//               with one cycle of latency (same-cycle writes forwarded), and
//               buffers retired (pc, rd_value) records for the checker.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               wb_en, wb_addr, wb_data     - core register-file write
//               ret_valid, ret_pc           - instruction retire
//               rs, rt                      - checker query indices
//               rs_value, rt_value          - registered query results
//               ev_valid, ev_ready          - retire record handshake
//               pc, rd_value                - head retire record
//               overflow                    - sticky retire-drop flag
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_state_tap
    import cpu_check_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ret_valid,
    input  logic [XLEN-1:0] ret_pc,
    input  logic [4:0]      rs,
    input  logic [4:0]      rt,
    output logic [XLEN-1:0] rs_value,
    output logic [XLEN-1:0] rt_value,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] rd_value,
    output logic            overflow
);

    logic [XLEN-1:0] r_rf [NUM_REGS];
    logic [XLEN-1:0] r_rs_value;
    logic [XLEN-1:0] r_rt_value;
    logic            r_overflow;

    logic            w_wr_live;
    logic [XLEN-1:0] w_rs_next;
    logic [XLEN-1:0] w_rt_next;
    retire_rec_t     w_push_rec;
    retire_rec_t     w_head;
    logic            w_empty;
    logic            w_drop;

    // Register 0 is hardwired; a write to it is not a live write.
    assign w_wr_live = wb_en && (wb_addr != REG_ZERO);

    // Shadow register file. Entry 0 is never written so it stays 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // Query lookup with same-cycle write forwarding so the checker sees the
    // value the core will hold after this edge.
    always_comb begin
        w_rs_next = r_rf[rs];
        w_rt_next = r_rf[rt];
        if (w_wr_live && (wb_addr == rs)) begin
            w_rs_next = wb_data;
        end
        if (w_wr_live && (wb_addr == rt)) begin
            w_rt_next = wb_data;
        end
        if (rs == REG_ZERO) begin
            w_rs_next = '0;
        end
        if (rt == REG_ZERO) begin
            w_rt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_value <= '0;
            r_rt_value <= '0;
        end else begin
            r_rs_value <= w_rs_next;
            r_rt_value <= w_rt_next;
        end
    end

    assign w_push_rec = make_retire_rec(ret_pc, wb_en, wb_addr, wb_data);

    retire_fifo #(
        .DEPTH (DEPTH)
    ) u_retire_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (ret_valid),
        .i_push_data (w_push_rec),
        .i_pop       (ev_ready),
        .o_head      (w_head),
        .o_empty     (w_empty),
        .o_drop      (w_drop)
    );

    // Once a retire is lost the checker's view is incomplete until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign rs_value = r_rs_value;
    assign rt_value = r_rt_value;
    assign ev_valid = !w_empty;
    assign pc       = w_head.pc;
    assign rd_value = w_head.rd_value;
    assign overflow = r_overflow;

endmodule : cpu_state_tap
`default_nettype wire

// File: tb/tb_cpu_state_tap.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_state_tap
// Description : Self-checking bench for cpu_state_tap. A reference model
//               (shadow register file, retire queue, sticky overflow) runs
//               alongside the DUT; query expectations are queued when a
//               query is driven and compared when the result appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_state_tap;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ret_valid;
    logic [31:0] ret_pc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        ev_valid;
    logic        ev_ready;
    logic [31:0] pc;
    logic [31:0] rd_value;
    logic        overflow;

    always #5 clk = ~clk;

    cpu_state_tap #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .rs        (rs),
        .rt        (rt),
        .rs_value  (rs_value),
        .rt_value  (rt_value),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .pc        (pc),
        .rd_value  (rd_value),
        .overflow  (overflow)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] rd;
    } rec_t;

    int          n_checks = 0;
    int          n_errors = 0;

    logic [31:0] m_rf [32];
    rec_t        m_fifo [$];
    logic [63:0] q_query [$];
    logic        m_ovf;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_fifo.delete();
        q_query.delete();
        m_ovf     = 1'b0;
        m_last_pc = 32'd0;
        m_last_rd = 32'd0;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic rv, input logic [31:0] rp,
                         input logic [4:0] qs, input logic [4:0] qt, input logic er);
        wb_en = we; wb_addr = wa; wb_data = wd;
        ret_valid = rv; ret_pc = rp;
        rs = qs; rt = qt; ev_ready = er;
    endtask

    function automatic logic [31:0] model_query(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_rf[idx];
    endfunction

    // One clock cycle: check event outputs, advance the model, clock the DUT,
    // then compare the query results that were queued for this edge.
    task automatic step();
        logic [63:0] q;
        rec_t        r;
        bit          do_pop;
        chk("ev_valid", {31'd0, ev_valid}, {31'd0, m_fifo.size() != 0});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (m_fifo.size() != 0) begin
            chk("head_pc", pc, m_fifo[0].pc);
            chk("head_rd", rd_value, m_fifo[0].rd);
        end else begin
            chk("idle_pc", pc, m_last_pc);
            chk("idle_rd", rd_value, m_last_rd);
        end

        q_query.push_back({model_query(rs), model_query(rt)});

        do_pop = (m_fifo.size() != 0) && ev_ready;
        if (do_pop) begin
            m_last_pc = m_fifo[0].pc;
            m_last_rd = m_fifo[0].rd;
            void'(m_fifo.pop_front());
        end
        if (ret_valid) begin
            if (m_fifo.size() >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                r.pc = ret_pc;
                r.rd = (wb_en && wb_addr != 5'd0) ? wb_data : 32'd0;
                m_fifo.push_back(r);
            end
        end
        if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;

        @(posedge clk);
        #1;
        q = q_query.pop_front();
        chk("rs_value", rs_value, q[63:32]);
        chk("rt_value", rt_value, q[31:0]);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear
    // without waiting for an edge.
    task automatic apply_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rs_value", rs_value, 32'd0);
        chk("rst_rt_value", rt_value, 32'd0);
        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_rd_value", rd_value, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        model_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        apply_reset();

        // Write then query; write to r0 must not stick.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0); step();
        drive(1'b1, 5'd0, 32'h00001234, 1'b0, 32'd0, 5'd5, 5'd0, 1'b0); step();
        chk("t2_rs5", rs_value, 32'hDEADBEEF);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5, 5'd0, 1'b0); step();
        chk("t2_rt0", rt_value, 32'd0);

        // Same-cycle forwarding; also rs == rt.
        drive(1'b1, 5'd7, 32'h11111111, 1'b0, 32'd0, 5'd0, 5'd0, 1'b0); step();
        drive(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 32'd0, 5'd7, 5'd7, 1'b0); step();
        chk("t3_fwd_rs", rs_value, 32'hA5A5A5A5);
        chk("t3_fwd_rt", rt_value, 32'hA5A5A5A5);

        // Three retires, popped in order; last has no write.
        drive(1'b1, 5'd3, 32'h00000111, 1'b1, 32'h00400000, 5'd3, 5'd4, 1'b1); step();
        chk("t4_first_pc", pc, 32'h00400000);
        drive(1'b1, 5'd4, 32'h00000222, 1'b1, 32'h00400004, 5'd3, 5'd4, 1'b1); step();
        chk("t4_second_pc", pc, 32'h00400004);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 32'h00400008, 5'd3, 5'd4, 1'b1); step();
        chk("t4_third_pc", pc, 32'h00400008);
        chk("t4_third_rd", rd_value, 32'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd0, 5'd0, 1'b1); step();
        chk("t4_drained", {31'd0, ev_valid}, 32'd0);
        chk("t4_hold_pc", pc, 32'h00400008);

        // Fill past capacity with no pops, then pop+push at full.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'(8 + i), 32'hC000_0000 + i, 1'b1, 32'h1000 + 32'(i * 4),
                  5'd8, 5'd9, 1'b0);
            step();
        end
        chk("t5_overflow", {31'd0, overflow}, 32'd1);
        chk("t5_head_pc", pc, 32'h00001000);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 32'h00002000, 5'd10, 5'd12, 1'b1); step();
        chk("t5_head_after", pc, 32'h00001004);
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd11, 5'd0, 1'b1);
            step();
        end
        chk("t5_sticky", {31'd0, overflow}, 32'd1);
        chk("t5_last_pc", pc, 32'h00002000);

        apply_reset();

        // Randomised traffic against the model.
        for (int c = 0; c < 10000; c++) begin
            logic [4:0] a;
            a = 5'($urandom_range(0, 31));
            drive($urandom_range(0, 9) < 6, a, $urandom,
                  $urandom_range(0, 1) == 1, $urandom,
                  ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)),
                  $urandom_range(0, 9) < 4);
            step();
        end

        // Mid-stream reset with state present.
        apply_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 5'd5, 5'd7, 1'b0); step();
        chk("post_rst_rf5", rs_value, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cpu_state_tap
`default_nettype wire
